parser_rule_cfg_ctrl: RTL
=========================

// Module: parser_rule_cfg_ctrl
// PURPOSE
// Sequences rule-table configuration into the pipelined parser/deparser stages. Sits between the CPU
// config path and the stages' rule ports, and decodes 3-flit config commands. Before any write it
// quiesces PHV injection and drains in-flight PHVs, then issues one wren/rden pulse. Reads are
// returned as a 3-flit response; stage 0 writes go to the initial type-info register.
// PARAMETERS
// NUM_STAGE    3     parser stages driven (stage select 1..NUM_STAGE; 0 = type-info register)
// RULE_W       177   rule width (data_rule)
// TIMEOUT_CYC  64    cycles to wait for rdata_rule_valid before an error response
// PORTS
// clk               in   1           clock
// rst_n             in   1           async active-low reset
// cfg_in_wr         in   1           config flit valid
// cfg_in            in   134         flit; payload in [127:0]
// cfg_in_ready      out  1           1 only in IDLE/DATA_HI/DATA_LO
// phv_in_valid      in   1           PHV entering stage 1 (in-flight +1)
// phv_out_valid     in   1           PHV leaving last stage (in-flight -1)
// phv_hold          out  1           1 = ingress must not start a new PHV
// wren_rule         out  NUM_STAGE   one-hot 1-cycle write strobe, bit s-1 = stage s
// rden_rule         out  NUM_STAGE   one-hot 1-cycle read strobe
// addr_rule         out  3           rule address
// data_rule         out  RULE_W      rule data, stable from ISSUE to next command
// rdata_rule_valid  in   NUM_STAGE   per-stage read-data valid
// rdata_rule_flat   in   NUM_STAGE*RULE_W  stage s data at [s*RULE_W-1:(s-1)*RULE_W]
// type_info         out  160         initial type info for PHV [2207:2048]
// resp_wr           out  1           response flit valid
// resp_data         out  134         response flit
// resp_ready        in   1           downstream may accept response flits
// BEHAVIOUR
// Reset: all outputs 0. type_info=0, in-flight count=0, state IDLE.
// Header flit (IDLE, cfg_in_wr & cfg_in[0]=1): rd=[8], addr=[18:16], stage=[25:24]. Flits with [0]=0 are ignored.
// States: IDLE -> DATA_HI -> DATA_LO -> DRAIN -> ISSUE -> (WAIT_RD -> RESP0 -> RESP1 -> RESP2 |
//   IDLE). The flit after the header -> data[176:128] = cfg_in[48:0]; the next -> data[127:0] = cfg_in[127:0].
//   Every command carries both data flits; read data is ignored.
// phv_hold is registered: set on DATA_LO acceptance and cleared on return to IDLE.
// In-flight count is 4b: +1 on phv_in_valid, -1 on phv_out_valid, unchanged when both fire.
//   It saturates at 15 and does not go below 0.
// DRAIN leaves when count==0 (next cycle ISSUE). A read skips the drain wait only if stage==0.
// ISSUE (1 cycle):
//   stage 0 write -> type_info <= {data[176:128], data[127:0]} (low 160b of 177).
//   stage s>=1 write -> wren_rule[s-1]=1 for exactly 1 cycle, then IDLE.
//   read s>=1 -> rden_rule[s-1]=1, then WAIT_RD.
//   read stage 0 -> response built from type_info.
//   stage>NUM_STAGE -> no strobe; error response.
// WAIT_RD: capture the selected stage's data on rdata_rule_valid[s-1]. Other stages' valid bits are ignored.
//   If no valid after TIMEOUT_CYC cycles -> respond with status=error, data=0.
// Response: resp_wr=1 holds the flit until resp_ready=1 (flit advances on resp_wr&resp_ready).
//   RESP0 [133:132]=2'b01, [127:0] = echo header with [9]=error bit.
//   RESP1 [133:132]=2'b11, [48:0]=data[176:128].
//   RESP2 [133:132]=2'b10, [127:0]=data[127:0]. Then IDLE.
// Writes produce no response. A command is fully processed before the next header is accepted.
// cfg_in_wr while cfg_in_ready=0 is dropped (source must honour ready).
// Async reset mid-command aborts it: no strobe fires and phv_hold drops immediately.
// TESTING
// Write stage2 addr5 data 177'h1_2345_..._ABCD with count=0 -> wren_rule=3'b010 for 1 cycle,
//   addr_rule=5, data_rule matches, no resp.
// Same write with 3 PHVs in flight -> phv_hold=1, no wren until 3 phv_out_valid. Then wren 1 cycle after count hits 0.
// Read stage3 addr2, model returns valid after 4 cycles -> rden_rule=3'b100 once.
//   Then 3 resp flits with [133:132]=01/11/10 and data matching; resp_ready low 5 cycles stalls flit 2 unchanged.
// Read stage1 with no rdata_rule_valid -> after 64 cycles RESP0 bit[9]=1, data flits 0.
// Stage0 write of 160'hDEAD..BEEF -> type_info updates, no wren/rden, phv_hold cleared.
// Reset asserted in WAIT_RD -> all outputs 0 next edge. A following write command then completes normally.

Source files
------------

// File: rtl/parser_rule_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// parser_rule_cfg_ctrl
//
// Takes 3-flit configuration commands from the CPU config path and sequences
// them into the rule ports of the pipelined parser/deparser stages.
//
// Flit 0 is the header: [0]=1 marks it, [8]=read, [18:16]=rule address, and
// [25:24]=stage. Stage 0 selects the initial type-info register.
// Flit 1 carries rule data [RULE_W-1:128] in [RULE_W-129:0].
// Flit 2 carries rule data [127:0].
//
// Before anything touches the rule tables, PHV ingress is held and in-flight
// PHVs are drained. Then one wren/rden strobe fires. A read returns a 3-flit
// response on resp_*.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_in_wr/cfg_in    config flit in; cfg_in_ready is high while a flit
//                       can be taken (IDLE, DATA_HI, DATA_LO)
//   phv_in_valid        PHV entering stage 1 (in-flight +1)
//   phv_out_valid       PHV leaving the last stage (in-flight -1)
//   phv_hold            ingress must not start a new PHV
//   wren_rule/rden_rule one-hot single-cycle strobes, bit s-1 = stage s
//   addr_rule/data_rule rule address and data for the strobed stage
//   rdata_rule_valid    per-stage read-data valid
//   rdata_rule_flat     per-stage read data, stage s at [s*RULE_W-1 -: RULE_W]
//   type_info           initial type info for new PHVs
//   resp_wr/resp_data   response flit, held until resp_ready
//   resp_ready          downstream accepts a response flit
// -----------------------------------------------------------------------------
module parser_rule_cfg_ctrl #(
    parameter int NUM_STAGE   = 3,
    parameter int RULE_W      = 177,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_in_wr,
    input  logic [133:0]                  cfg_in,
    output logic                          cfg_in_ready,
    input  logic                          phv_in_valid,
    input  logic                          phv_out_valid,
    output logic                          phv_hold,
    output logic [NUM_STAGE-1:0]          wren_rule,
    output logic [NUM_STAGE-1:0]          rden_rule,
    output logic [2:0]                    addr_rule,
    output logic [RULE_W-1:0]             data_rule,
    input  logic [NUM_STAGE-1:0]          rdata_rule_valid,
    input  logic [NUM_STAGE*RULE_W-1:0]   rdata_rule_flat,
    output logic [159:0]                  type_info,
    output logic                          resp_wr,
    output logic [133:0]                  resp_data,
    input  logic                          resp_ready
);

    localparam int          HI_W        = RULE_W - 128;
    localparam int          TO_W        = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [31:0] NUM_STAGE_U = NUM_STAGE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DATA_HI,
        S_DATA_LO,
        S_DRAIN,
        S_ISSUE,
        S_WAIT_RD,
        S_RESP0,
        S_RESP1,
        S_RESP2
    } state_t;

    state_t              state_reg;
    logic [127:0]        hdr_reg;
    logic                rd_reg;
    logic [1:0]          stage_reg;
    logic [RULE_W-1:0]   rbuf_reg;
    logic [TO_W-1:0]     timer_reg;
    logic [3:0]          count_reg;

    // The stage field is two bits wide, so the per-stage views are padded to
    // four entries. Any entry beyond NUM_STAGE reads as zero and is never
    // selected, because stage_ok gates its use.
    logic [RULE_W-1:0]   slice_sel [4];
    logic [3:0]          valid_sel;
    logic [1:0]          stage_idx;
    logic                stage_ok;
    logic [NUM_STAGE-1:0] stage_onehot;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            if (gi < NUM_STAGE) begin : g_real
                assign slice_sel[gi] = rdata_rule_flat[gi*RULE_W +: RULE_W];
                assign valid_sel[gi] = rdata_rule_valid[gi];
            end else begin : g_pad
                assign slice_sel[gi] = '0;
                assign valid_sel[gi] = 1'b0;
            end
        end
    endgenerate

    assign stage_idx    = stage_reg - 2'd1;
    assign stage_ok     = (stage_reg != 2'd0) && ({30'd0, stage_reg} <= NUM_STAGE_U);
    assign stage_onehot = NUM_STAGE'(1) << stage_idx;

    // Header bit 9 is overwritten by the error flag in the echo. Bits
    // [133:128] of cfg_in carry nothing this block uses.
    logic unused_bits;
    assign unused_bits = ^{cfg_in[133:128], hdr_reg[9]};

    // Builds the first response flit: the header is echoed back with bit 9
    // replaced by the error flag.
    function automatic logic [133:0] resp0_flit(input logic [127:0] h, input logic e);
        return {2'b01, 4'b0000, h[127:10], e, h[8:0]};
    endfunction

    // In-flight PHV counter. It saturates at both ends. A simultaneous
    // enter and leave cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 4'd0;
        end else begin
            case ({phv_in_valid, phv_out_valid})
                2'b10:   if (count_reg != 4'd15) count_reg <= count_reg + 4'd1;
                2'b01:   if (count_reg != 4'd0)  count_reg <= count_reg - 4'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            hdr_reg      <= '0;
            rd_reg       <= 1'b0;
            stage_reg    <= 2'd0;
            rbuf_reg     <= '0;
            timer_reg    <= '0;
            cfg_in_ready <= 1'b0;
            phv_hold     <= 1'b0;
            wren_rule    <= '0;
            rden_rule    <= '0;
            addr_rule    <= 3'd0;
            data_rule    <= '0;
            type_info    <= '0;
            resp_wr      <= 1'b0;
            resp_data    <= '0;
        end else begin
            // The strobes are single-cycle. Set only on the DRAIN->ISSUE edge.
            wren_rule <= '0;
            rden_rule <= '0;

            case (state_reg)
                S_IDLE: begin
                    cfg_in_ready <= 1'b1;
                    if (cfg_in_wr && cfg_in_ready && cfg_in[0]) begin
                        hdr_reg   <= cfg_in[127:0];
                        rd_reg    <= cfg_in[8];
                        addr_rule <= cfg_in[18:16];
                        stage_reg <= cfg_in[25:24];
                        state_reg <= S_DATA_HI;
                    end
                end

                S_DATA_HI: begin
                    if (cfg_in_wr) begin
                        data_rule[RULE_W-1:128] <= cfg_in[HI_W-1:0];
                        state_reg               <= S_DATA_LO;
                    end
                end

                S_DATA_LO: begin
                    if (cfg_in_wr) begin
                        data_rule[127:0] <= cfg_in[127:0];
                        phv_hold         <= 1'b1;
                        cfg_in_ready     <= 1'b0;
                        state_reg        <= S_DRAIN;
                    end
                end

                // A read of the type-info register does not disturb PHVs,
                // so it does not need to wait for the pipeline to empty.
                S_DRAIN: begin
                    if (count_reg == 4'd0 || (rd_reg && stage_reg == 2'd0)) begin
                        state_reg <= S_ISSUE;
                        if (stage_ok) begin
                            if (rd_reg) rden_rule <= stage_onehot;
                            else        wren_rule <= stage_onehot;
                        end
                    end
                end

                S_ISSUE: begin
                    if (stage_reg == 2'd0) begin
                        if (rd_reg) begin
                            rbuf_reg  <= RULE_W'(type_info);
                            resp_data <= resp0_flit(hdr_reg, 1'b0);
                            resp_wr   <= 1'b1;
                            state_reg <= S_RESP0;
                        end else begin
                            type_info    <= data_rule[159:0];
                            phv_hold     <= 1'b0;
                            cfg_in_ready <= 1'b1;
                            state_reg    <= S_IDLE;
                        end
                    end else if (!stage_ok) begin
                        rbuf_reg  <= '0;
                        resp_data <= resp0_flit(hdr_reg, 1'b1);
                        resp_wr   <= 1'b1;
                        state_reg <= S_RESP0;
                    end else if (rd_reg) begin
                        timer_reg <= '0;
                        state_reg <= S_WAIT_RD;
                    end else begin
                        phv_hold     <= 1'b0;
                        cfg_in_ready <= 1'b1;
                        state_reg    <= S_IDLE;
                    end
                end

                S_WAIT_RD: begin
                    if (valid_sel[stage_idx]) begin
                        rbuf_reg  <= slice_sel[stage_idx];
                        resp_data <= resp0_flit(hdr_reg, 1'b0);
                        resp_wr   <= 1'b1;
                        state_reg <= S_RESP0;
                    end else if (timer_reg == TO_W'(TIMEOUT_CYC - 1)) begin
                        rbuf_reg  <= '0;
                        resp_data <= resp0_flit(hdr_reg, 1'b1);
                        resp_wr   <= 1'b1;
                        state_reg <= S_RESP0;
                    end else begin
                        timer_reg <= timer_reg + TO_W'(1);
                    end
                end

                S_RESP0: begin
                    if (resp_ready) begin
                        resp_data <= {2'b11, 4'b0000, {(128-HI_W){1'b0}}, rbuf_reg[RULE_W-1:128]};
                        state_reg <= S_RESP1;
                    end
                end

                S_RESP1: begin
                    if (resp_ready) begin
                        resp_data <= {2'b10, 4'b0000, rbuf_reg[127:0]};
                        state_reg <= S_RESP2;
                    end
                end

                S_RESP2: begin
                    if (resp_ready) begin
                        resp_wr      <= 1'b0;
                        resp_data    <= '0;
                        phv_hold     <= 1'b0;
                        cfg_in_ready <= 1'b1;
                        state_reg    <= S_IDLE;
                    end
                end

                default: begin
                    phv_hold     <= 1'b0;
                    cfg_in_ready <= 1'b1;
                    state_reg    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
